// File: rtl/keccak_pkg.sv
// Shared Keccak-f[1600] types, constants and index helpers.
package keccak_pkg;

    localparam int NX        = 5;
    localparam int NY        = 5;
    localparam int W_DEFAULT = 64;

    // Last row index of the 5-row iteration.
    localparam logic [2:0] ROW_LAST = 3'd4;

    typedef logic [W_DEFAULT-1:0] lane_t;
    typedef lane_t [NY-1:0]       plane_t;
    typedef lane_t [NX-1:0][NY-1:0] state_t;

    typedef enum logic [1:0] {
        IDLE,
        PARITY,
        APPLY,
        DONE
    } theta_st_e;

    // (i + 1) mod 5 for i in 0..4.
    function automatic int mod5_inc(input int i);
        return (i == NX - 1) ? 0 : i + 1;
    endfunction

    // (i - 1) mod 5 for i in 0..4.
    function automatic int mod5_dec(input int i);
        return (i == 0) ? NX - 1 : i - 1;
    endfunction

endpackage

// File: rtl/theta_d_gen.sv
// Theta D-mix: D[x] = C[x-1] ^ rotl(C[x+1], 1), x indices mod 5.
module theta_d_gen
    import keccak_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [NX-1:0][W-1:0] c,
    output logic [NX-1:0][W-1:0] d
);

    for (genvar x = 0; x < NX; x++) begin : g_col
        localparam int XM = mod5_dec(x);
        localparam int XP = mod5_inc(x);
        // Rotating left by one moves bit W-1 of C[x+1] into z=0.
        assign d[x] = c[XM] ^ {c[XP][W-2:0], c[XP][W-1]};
    end

endmodule

// File: rtl/theta_seq.sv
// Iterative Keccak theta: five cycles folding rows into the column parities,
// five cycles applying the D-mix row by row, then a held result for rho.
module theta_seq
    import keccak_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4:0][4:0][W-1:0]     in_state,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [4:0][4:0][W-1:0]     out_state,
    output logic                       busy
);

    theta_st_e                 st;
    logic [2:0]                row;
    logic [NX-1:0][W-1:0]      c_par;
    logic [NX-1:0][W-1:0]      d_mix;
    logic [4:0][4:0][W-1:0]    work_buf;
    logic                      accept;

    theta_d_gen #(.W(W)) u_d_gen (
        .c (c_par),
        .d (d_mix)
    );

    // A finished result may hand over and take the next state on one edge.
    assign in_ready = (st == IDLE) || ((st == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (st == PARITY) || (st == APPLY);

    // The buffer is both the working state and the output register, so the
    // result cannot change while it is being offered downstream.
    assign out_state = work_buf;

    // Sequencer: accept, fold rows into C, apply D per row, hold the result.
    // NOTE: every register here is written with <= so all reads in one edge
    // see the pre-edge values (C and the buffer are read and written together).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            row       <= '0;
            c_par     <= '0;
            // NOTE: the wide buffer is reset on purpose; it drives out_state
            // directly, and a discarded in-flight state must not stay visible.
            work_buf  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (accept) begin
                        work_buf <= in_state;
                        c_par    <= '0;
                        row      <= '0;
                        st       <= PARITY;
                    end
                end

                PARITY: begin
                    for (int x = 0; x < NX; x++) begin
                        c_par[x] <= c_par[x] ^ work_buf[x][row];
                    end
                    if (row == ROW_LAST) begin
                        row <= '0;
                        st  <= APPLY;
                    end else begin
                        row <= row + 3'd1;
                    end
                end

                APPLY: begin
                    for (int x = 0; x < NX; x++) begin
                        work_buf[x][row] <= work_buf[x][row] ^ d_mix[x];
                    end
                    if (row == ROW_LAST) begin
                        row       <= '0;
                        st        <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        row <= row + 3'd1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            work_buf <= in_state;
                            c_par    <= '0;
                            row      <= '0;
                            st       <= PARITY;
                        end else begin
                            st <= IDLE;
                        end
                    end
                end

                default: begin
                    st        <= IDLE;
                    row       <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/theta_seq.md
Name: theta_seq

Overview:
- Iterative, area-reduced Keccak-f[1600] theta step.
- Sits directly upstream of the combinational rho stage and drives its theta input.
- Accepts a full 5x5x64 state over a valid/ready handshake and computes the column parities C[x] row by row.
- Applies the theta D-mix row by row, then presents the result to rho with a valid/ready handshake.
- Trades roughly 10 cycles of latency for a single-row XOR datapath instead of a full 1600-bit theta array.

Parameters:
- W, 64, lane width in bits. Keccak-f[1600] requires 64; the parameter exists for reduced-width test configurations.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_state is valid.
- in_ready  output  1  block can accept a state this cycle.
- in_state  input  [4:0][4:0][W-1:0]  input state, indexed [x][y][z].
- out_valid  output  1  out_state holds a completed theta result.
- out_ready  input  1  downstream (rho path) accepts out_state.
- out_state  output  [4:0][4:0][W-1:0]  theta result, same indexing, feeds rho.theta.
- busy  output  1  high in PARITY or APPLY.

Behaviour:
- FSM states: IDLE, PARITY, APPLY, DONE. Row counter row[2:0] ranges 0..4.
- Reset (async): FSM=IDLE, row=0, parity register C=0, working buffer=0, out_state=0, out_valid=0, busy=0. in_ready is combinational and reads 1 while in reset.
- in_ready = (FSM==IDLE) | (FSM==DONE & out_ready).
- Accept: on an edge with in_valid & in_ready, capture in_state into the buffer, clear C, set row=0, go to PARITY.
- PARITY: each cycle, for all x, C[x] ^= buf[x][row].
  - row increments each cycle.
  - When row==4, go to APPLY with row=0.
- D-mix: D[x][z] = C[(x+4)%5][z] ^ C[(x+1)%5][(z+W-1)%W], i.e. the C[x+1] lane rotated left by 1.
- APPLY: each cycle, for all x, buf[x][row] ^= D[x].
  - row increments each cycle.
  - When row==4, go to DONE with out_valid=1.
- out_state is driven from the buffer. It is stable and unchanged for the whole time out_valid=1.
- Latency: out_valid rises 10 rising edges after the accept edge (5 PARITY + 5 APPLY). Throughput is 1 state per 11 cycles with back-to-back handshakes.
- DONE, out_ready=0: hold out_valid and out_state; in_ready=0; in_valid is ignored.
- DONE, out_ready=1, in_valid=0: out_valid falls at the next edge; go to IDLE.
- DONE, out_ready=1, in_valid=1 (same cycle): complete the output transfer and accept the new state at the same edge. Go to PARITY with out_valid=0 and no idle bubble.
- in_valid while busy: ignored; in_ready=0. The upstream source must hold in_state until in_ready.
- Reset asserted mid-PARITY/APPLY: the in-flight state is discarded and no output is produced.
- Index wrap-around: x indices wrap mod 5; z rotation wraps mod W (bit W-1 of C[x+1] maps to z=0).
- No combinational path from in_state to out_state. The only in->out combinational path is out_ready->in_ready.

Decomposition:
- Package keccak_pkg holds:
  - constants NX=5, NY=5, W_DEFAULT=64;
  - typedefs lane_t (logic [W-1:0]), plane_t ([4:0] lane_t), state_t ([4:0][4:0] lane_t);
  - FSM enum theta_st_e {IDLE, PARITY, APPLY, DONE};
  - functions mod5_inc / mod5_dec.
- Sub-module theta_d_gen (combinational): input plane_t C, output plane_t D, implementing the D-mix formula above. Shared with any future full-parallel theta.

Test Plan:
- All-zero in_state, out_ready=1 -> out_valid exactly 10 edges after accept; out_state all zero; busy high for 10 cycles.
- Single bit in_state[0][0][0]=1 -> out_state has exactly 11 ones: [0][0][0], [1][y][0] for y=0..4, and [4][y][1] for y=0..4.
- Even-parity column: bits [2][0][5] and [2][3][5] set -> C=0, so out_state equals in_state.
- All-ones in_state -> out_state all ones (every C lane is all ones, so D=0); also compare 50 random states against a golden theta model.
- Backpressure and back-to-back: hold out_ready=0 for 20 cycles -> out_valid and out_state stable, in_ready=0. Then raise out_ready with in_valid=1 in the same cycle -> transfer and accept on one edge; second result appears 10 edges later.
- Assert rst for 1 cycle at the 3rd PARITY cycle -> out_valid=0, out_state=0, in_ready=1 immediately; no stale result ever appears.
